// File: rtl/cache_data_bank.sv
// cache_data_bank: NUM_WAYS x NUM_SETS cache data store with per-way,
// per-byte write enables, a registered 1-cycle read of all ways of a set,
// write-first forwarding, and a post-reset init sweep that zeroes storage.
// Optional build macro: CACHE_DATA_PARITY_EN adds per-byte even parity
// storage and registered per-way read parity error flags.
module cache_data_bank #(
  parameter int unsigned S_INDEX    = 3,
  parameter int unsigned NUM_SETS   = 2**S_INDEX,
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned W_WAY      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               ready,
  input  logic                               rd_req,
  input  logic [S_INDEX-1:0]                 rd_index,
  output logic                               rd_valid,
  output logic [NUM_WAYS*8*LINE_BYTES-1:0]   rd_data,
  input  logic                               wr_en,
  input  logic [W_WAY-1:0]                   wr_way,
  input  logic [S_INDEX-1:0]                 wr_index,
  input  logic [LINE_BYTES-1:0]              wr_byte_en,
  input  logic [8*LINE_BYTES-1:0]            wr_data,
  output logic [NUM_WAYS-1:0]                rd_parity_err
);

  localparam int unsigned LW = 8 * LINE_BYTES;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                      state_q;
  logic [S_INDEX-1:0]          init_cnt_q;
  logic                        ready_q;
  logic                        rd_valid_q;
  logic [NUM_WAYS*LW-1:0]      rd_data_q;
  logic [NUM_WAYS*LW-1:0]      rd_data_d;
  logic                        way_ok;
  logic                        wr_fire;
  logic                        rd_fire;

  logic [LW-1:0]               mem_q [NUM_WAYS][NUM_SETS];

`ifdef CACHE_DATA_PARITY_EN
  logic [LINE_BYTES-1:0]       par_q [NUM_WAYS][NUM_SETS];
  logic [LINE_BYTES-1:0]       wr_par;
  logic [NUM_WAYS-1:0]         rd_perr_q;
  logic [NUM_WAYS-1:0]         rd_perr_d;
`endif

  // Requests are accepted only once the init sweep has finished.
  assign way_ok  = (32'(wr_way) < NUM_WAYS);
  assign wr_fire = ready_q && wr_en && way_ok;
  assign rd_fire = ready_q && rd_req;

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Init sweep FSM: one set per cycle, then ready until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + S_INDEX'(1);
          if (init_cnt_q == S_INDEX'(NUM_SETS - 1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
        end
      endcase
    end
  end

`ifdef CACHE_DATA_PARITY_EN
  // Even parity of each incoming write byte.
  always_comb begin
    wr_par = '0;
    for (int unsigned b = 0; b < LINE_BYTES; b++) begin
      wr_par[b] = ^wr_data[b*8 +: 8];
    end
  end
`endif

  // Storage: zeroed by the sweep, otherwise byte-masked writes.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        mem_q[w][init_cnt_q] <= '0;
`ifdef CACHE_DATA_PARITY_EN
        par_q[w][init_cnt_q] <= '0;
`endif
      end
    end else if (wr_fire) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (wr_byte_en[b]) begin
          mem_q[wr_way][wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
`ifdef CACHE_DATA_PARITY_EN
          par_q[wr_way][wr_index][b] <= wr_par[b];
`endif
        end
      end
    end
  end

  // Read mux with write-first bypass; parity bits are bypassed with the data
  // so a forwarded byte is always self-consistent.
  always_comb begin
    logic [LW-1:0] line;
    logic          bypass;
`ifdef CACHE_DATA_PARITY_EN
    logic [LINE_BYTES-1:0] pline;
    logic                  mism;
    rd_perr_d = '0;
    pline     = '0;
    mism      = 1'b0;
`endif
    rd_data_d = '0;
    line      = '0;
    bypass    = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      line   = mem_q[w][rd_index];
      bypass = wr_fire && (wr_index == rd_index) && (wr_way == W_WAY'(w));
`ifdef CACHE_DATA_PARITY_EN
      pline = par_q[w][rd_index];
`endif
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (bypass && wr_byte_en[b]) begin
          line[b*8 +: 8] = wr_data[b*8 +: 8];
`ifdef CACHE_DATA_PARITY_EN
          pline[b] = wr_par[b];
`endif
        end
      end
      rd_data_d[w*LW +: LW] = line;
`ifdef CACHE_DATA_PARITY_EN
      mism = 1'b0;
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        mism = mism | ((^line[b*8 +: 8]) ^ pline[b]);
      end
      rd_perr_d[w] = mism;
`endif
    end
  end

  // Registered read outputs; data holds until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef CACHE_DATA_PARITY_EN
      rd_perr_q  <= '0;
`endif
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= rd_data_d;
`ifdef CACHE_DATA_PARITY_EN
        rd_perr_q <= rd_perr_d;
`endif
      end
    end
  end

`ifdef CACHE_DATA_PARITY_EN
  assign rd_parity_err = rd_perr_q;
`else
  assign rd_parity_err = '0;
`endif

endmodule

// File: tb/tb_cache_data_bank.sv
// Directed self-checking bench for cache_data_bank (default parameters).
module tb_cache_data_bank;

  localparam int unsigned S_INDEX    = 3;
  localparam int unsigned NUM_WAYS   = 2;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned LW         = 8 * LINE_BYTES;
  localparam int unsigned DW         = NUM_WAYS * LW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ready;
  logic                   rd_req;
  logic [S_INDEX-1:0]     rd_index;
  logic                   rd_valid;
  logic [DW-1:0]          rd_data;
  logic                   wr_en;
  logic [0:0]             wr_way;
  logic [S_INDEX-1:0]     wr_index;
  logic [LINE_BYTES-1:0]  wr_byte_en;
  logic [LW-1:0]          wr_data;
  logic [NUM_WAYS-1:0]    rd_parity_err;

  int n_cmp  = 0;
  int n_fail = 0;

  cache_data_bank #(
    .S_INDEX    (S_INDEX),
    .NUM_WAYS   (NUM_WAYS),
    .LINE_BYTES (LINE_BYTES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ready         (ready),
    .rd_req        (rd_req),
    .rd_index      (rd_index),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_way        (wr_way),
    .wr_index      (wr_index),
    .wr_byte_en    (wr_byte_en),
    .wr_data       (wr_data),
    .rd_parity_err (rd_parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] fill(input logic [7:0] b);
    return {LINE_BYTES{b}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] pat;
    logic [LW-1:0] byp;
    logic [LW-1:0] pat3;
    int            cyc;

    rst = 1'b1; rd_req = 1'b0; rd_index = '0; wr_en = 1'b0; wr_way = '0;
    wr_index = '0; wr_byte_en = '0; wr_data = '0;

    // Reset state
    tick();
    chk32("rst_ready", ready, 0);
    chk32("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, '0);
    chk32("rst_perr", rd_parity_err, 0);

    // Init sweep with a read request held throughout
    rd_req = 1'b1; rd_index = 3'd5;
    tick();
    rst = 1'b0;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
      chk32("init_no_valid", rd_valid, 0);
    end
    chk32("init_latency", cyc, 8);
    // Read of set 5 accepted at the next edge
    tick();
    rd_req = 1'b0;
    chk32("set5_valid", rd_valid, 1);
    chk("set5_zero", rd_data, '0);
    chk32("set5_perr", rd_parity_err, 0);
    tick();
    chk32("set5_valid_pulse", rd_valid, 0);

    // Byte-masked writes to way 1 set 3
    for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
    wr_en = 1'b1; wr_way = 1'b1; wr_index = 3'd3; wr_byte_en = 32'h0000_00FF; wr_data = pat;
    tick();
    wr_byte_en = 32'hFF00_0000; wr_data = fill(8'hAA);
    tick();
    wr_byte_en = 32'h0000_0000; wr_data = fill(8'h5A);
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_index = 3'd3;
    tick();
    rd_req = 1'b0;
    pat3 = {64'hAAAA_AAAA_AAAA_AAAA, 128'h0, 64'h0706_0504_0302_0100};
    chk32("mask_valid", rd_valid, 1);
    chk("mask_set3", rd_data, {pat3, 256'h0});

    // Write-first bypass on set 2 way 0
    wr_en = 1'b1; wr_way = 1'b0; wr_index = 3'd2; wr_byte_en = '1; wr_data = fill(8'h11);
    tick();
    wr_byte_en = 32'h0000_000F; wr_data = fill(8'hCC); wr_data[31:0] = 32'hDEAD_BEEF;
    rd_req = 1'b1; rd_index = 3'd2;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    byp = fill(8'h11); byp[31:0] = 32'hDEAD_BEEF;
    chk("bypass_set2", rd_data, {256'h0, byp});
    chk32("bypass_perr", rd_parity_err, 0);

    // Preload set 0 way 0 and set 1 way 1
    wr_en = 1'b1; wr_way = 1'b0; wr_index = 3'd0; wr_byte_en = '1; wr_data = fill(8'h01);
    tick();
    wr_way = 1'b1; wr_index = 3'd1; wr_data = fill(8'h22);
    tick();
    wr_en = 1'b0;

    // Back-to-back reads of sets 0..3; set 1 rewritten in the cycle after its read
    rd_req = 1'b1; rd_index = 3'd0;
    tick();
    chk32("pipe_v0", rd_valid, 1);
    chk("pipe_set0", rd_data, {256'h0, fill(8'h01)});
    rd_index = 3'd1;
    tick();
    chk32("pipe_v1", rd_valid, 1);
    chk("pipe_set1", rd_data, {fill(8'h22), 256'h0});
    rd_index = 3'd2; wr_en = 1'b1; wr_way = 1'b1; wr_index = 3'd1; wr_byte_en = '1; wr_data = fill(8'h77);
    #2;
    chk("pipe_set1_hold", rd_data, {fill(8'h22), 256'h0});
    tick();
    wr_en = 1'b0;
    chk32("pipe_v2", rd_valid, 1);
    chk("pipe_set2", rd_data, {256'h0, byp});
    rd_index = 3'd3;
    tick();
    rd_req = 1'b0;
    chk32("pipe_v3", rd_valid, 1);
    chk("pipe_set3", rd_data, {pat3, 256'h0});
    tick();
    chk32("pipe_v_drop", rd_valid, 0);
    chk("pipe_data_hold", rd_data, {pat3, 256'h0});
    rd_req = 1'b1; rd_index = 3'd1;
    tick();
    rd_req = 1'b0;
    chk("set1_rewritten", rd_data, {fill(8'h77), 256'h0});

    // Reset in the middle of a write burst with a read in flight
    rd_req = 1'b1; rd_index = 3'd0;
    wr_en = 1'b1; wr_way = 1'b0; wr_index = 3'd6; wr_byte_en = '1; wr_data = fill(8'h55);
    tick();
    chk32("burst_valid", rd_valid, 1);
    wr_index = 3'd7;
    #3 rst = 1'b1;
    #1;
    chk32("midrst_ready", ready, 0);
    chk32("midrst_valid", rd_valid, 0);
    chk("midrst_data", rd_data, '0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
      chk32("resweep_no_valid", rd_valid, 0);
    end
    chk32("resweep_latency", cyc, 8);
    wr_en = 1'b0; rd_req = 1'b0;
    tick();
    for (int s = 0; s < 8; s++) begin
      rd_req = 1'b1; rd_index = 3'(s);
      tick();
      chk32("resweep_valid", rd_valid, 1);
      chk("resweep_zero", rd_data, '0);
    end
    rd_req = 1'b0;
    tick();
    chk32("resweep_v_drop", rd_valid, 0);

`ifdef CACHE_DATA_PARITY_EN
    // Corrupt way 0 set 4 with a single set bit and read it back
    force dut.mem_q[0][4] = 256'h1;
    rd_req = 1'b1; rd_index = 3'd4;
    tick();
    rd_req = 1'b0;
    chk32("par_err_way0", rd_parity_err, 32'h1);
    release dut.mem_q[0][4];
    rd_req = 1'b1; rd_index = 3'd5;
    tick();
    rd_req = 1'b0;
    chk32("par_clean", rd_parity_err, 0);
    // Bypassed write over the corrupted byte clears the flag
    rd_req = 1'b1; rd_index = 3'd4;
    wr_en = 1'b1; wr_way = 1'b0; wr_index = 3'd4; wr_byte_en = 32'h0000_0001; wr_data = '0;
    tick();
    rd_req = 1'b0; wr_en = 1'b0;
    chk32("par_bypass_clear", rd_parity_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
